// File: rtl/window_generator.sv
// Streaming KxK sliding-window generator: row-delay lines feed a KxK register
// window, with row/column tracking, strided window-valid and frame-end pulses.
module window_generator #(
   parameter int KERNEL_SIZE = 3,
   parameter int DATA_SIZE   = 8,
   parameter int ROW_SIZE    = 5,
   parameter int COL_SIZE    = 5,
   parameter int STRIDE      = 1
) (
   input  logic                                       clock,
   input  logic                                       reset_n,
   input  logic                                       data_valid,
   input  logic [DATA_SIZE-1:0]                       data_in,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_out,
   output logic                                       window_valid,
   output logic                                       frame_done
);

   localparam int K  = KERNEL_SIZE;
   localparam int CW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int RW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [CW-1:0] COL_LAST        = CW'(ROW_SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST        = RW'(COL_SIZE - 1);
   localparam logic [CW-1:0] COL_FIRST_VALID = CW'(K - 1);
   localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(K - 1);
   localparam logic [SW-1:0] PHASE_RELOAD    = SW'(STRIDE - 1);

   logic [DATA_SIZE-1:0] line_buf [K-1][ROW_SIZE];
   logic [DATA_SIZE-1:0] win      [K][K];

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [SW-1:0] col_phase;
   logic [SW-1:0] row_phase;

   logic          col_end;
   logic          frame_end;
   logic          hit;
   logic [SW-1:0] col_phase_next;
   logic [SW-1:0] row_phase_next;

   // Phase counters are forced to 0 until the first valid column/row, so the
   // stride grid is anchored at K-1 and then counts down modulo STRIDE.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      col_end        = (col == COL_LAST);
      frame_end      = col_end && (row == ROW_LAST);
      hit            = (row >= ROW_FIRST_VALID) && (col >= COL_FIRST_VALID) &&
                       (row_phase == '0) && (col_phase == '0);
      col_phase_next = '0;
      row_phase_next = row_phase;
      if ((col >= COL_FIRST_VALID) && !col_end)
         col_phase_next = (col_phase == '0) ? PHASE_RELOAD : col_phase - 1'b1;
      if (col_end) begin
         row_phase_next = '0;
         if ((row >= ROW_FIRST_VALID) && (row != ROW_LAST))
            row_phase_next = (row_phase == '0) ? PHASE_RELOAD : row_phase - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col          <= '0;
         row          <= '0;
         col_phase    <= '0;
         row_phase    <= '0;
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         window_valid <= 1'b0;
         frame_done   <= 1'b0;
         if (data_valid) begin
            window_valid <= hit;
            frame_done   <= frame_end;
            col          <= col_end ? '0 : col + 1'b1;
            col_phase    <= col_phase_next;
            row_phase    <= row_phase_next;
            if (col_end)
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end
      end
   end

   // NOTE: the delay lines and window are flops with reset, so a mid-frame reset leaves no stale pixels behind.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < K-1; k++)
            for (int n = 0; n < ROW_SIZE; n++)
               line_buf[k][n] <= '0;
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
               win[i][j] <= '0;
      end else if (data_valid) begin
         line_buf[0][0] <= data_in;
         for (int k = 1; k < K-1; k++)
            line_buf[k][0] <= line_buf[k-1][ROW_SIZE-1];
         for (int k = 0; k < K-1; k++)
            for (int n = 1; n < ROW_SIZE; n++)
               line_buf[k][n] <= line_buf[k][n-1];

         for (int i = 0; i < K; i++)
            for (int j = 0; j < K-1; j++)
               win[i][j] <= win[i][j+1];
         // Oldest row (top) comes from the deepest delay line.
         for (int i = 0; i < K-1; i++)
            win[i][K-1] <= line_buf[K-2-i][ROW_SIZE-1];
         win[K-1][K-1] <= data_in;
      end
   end

   always_comb begin
      window_out = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            window_out[(i*K+j)*DATA_SIZE +: DATA_SIZE] = win[i][j];
   end

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: a frame-image model queues expected
// windows/frame_done pulses per instance; per-instance monitors pop and compare.
module tb_window_generator;

   typedef logic [299:0] wide_t;
   typedef struct {
      int    cyc;
      wide_t win;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        dv8;
   logic [7:0]  din8;
   logic        dv12;
   logic [11:0] din12;

   logic [71:0]  wo_a, wo_b;
   logic [299:0] wo_c, wo_d;
   logic         wv_a, wv_b, wv_c, wv_d;
   logic         fd_a, fd_b, fd_c, fd_d;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   window_generator #(.KERNEL_SIZE(3), .DATA_SIZE(8), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .data_valid(dv8), .data_in(din8),
      .window_out(wo_a), .window_valid(wv_a), .frame_done(fd_a));
   window_generator #(.KERNEL_SIZE(3), .DATA_SIZE(8), .ROW_SIZE(5), .COL_SIZE(5), .STRIDE(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .data_valid(dv8), .data_in(din8),
      .window_out(wo_b), .window_valid(wv_b), .frame_done(fd_b));
   window_generator #(.KERNEL_SIZE(5), .DATA_SIZE(12), .ROW_SIZE(8), .COL_SIZE(6), .STRIDE(1)) dut_c (
      .clock(clock), .reset_n(reset_n), .data_valid(dv12), .data_in(din12),
      .window_out(wo_c), .window_valid(wv_c), .frame_done(fd_c));
   window_generator #(.KERNEL_SIZE(5), .DATA_SIZE(12), .ROW_SIZE(8), .COL_SIZE(6), .STRIDE(3)) dut_d (
      .clock(clock), .reset_n(reset_n), .data_valid(dv12), .data_in(din12),
      .window_out(wo_d), .window_valid(wv_d), .frame_done(fd_d));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Reference model state: the current frame image and the next raster position.
   int f3 [25];
   int f5 [48];
   int r3 = 0, c3 = 0, r5 = 0, c5 = 0;

   exp_t  qa[$], qb[$], qc[$], qd[$];
   int    fqa[$], fqb[$], fqc[$], fqd[$];
   wide_t seen_a[$], seen_b[$], seen_c[$], seen_d[$];
   int    fd_cnt_a, fd_cnt_b, fd_cnt_c, fd_cnt_d;
   int    last_win_cyc_a, fd_cyc_a;
   exp_t  e_a, e_b, e_c, e_d;

   task automatic check(input string name, input wide_t act, input wide_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit hit(input int r, input int c, input int k, input int s);
      return (r >= k-1) && (c >= k-1) && ((r-k+1) % s == 0) && ((c-k+1) % s == 0);
   endfunction

   function automatic wide_t build3(input int r, input int c);
      wide_t w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[(i*3+j)*8 +: 8] = 8'(f3[(r-2+i)*5 + (c-2+j)]);
      return w;
   endfunction

   function automatic wide_t build5(input int r, input int c);
      wide_t w = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            w[(i*5+j)*12 +: 12] = 12'(f5[(r-4+i)*8 + (c-4+j)]);
      return w;
   endfunction

   function automatic wide_t pack3(input int a0, input int a1, input int a2,
                                   input int a3, input int a4, input int a5,
                                   input int a6, input int a7, input int a8);
      int    v [9];
      wide_t w = '0;
      v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      for (int k = 0; k < 9; k++)
         w[k*8 +: 8] = 8'(v[k]);
      return w;
   endfunction

   // Called at a negedge; the pixel is accepted at the next posedge and its
   // window/frame_done is visible at the negedge after that (cyc + 1).
   task automatic send3(input int p);
      exp_t e;
      din8 = 8'(p);
      dv8  = 1'b1;
      f3[r3*5 + c3] = p;
      if (hit(r3, c3, 3, 1)) begin e.cyc = cyc + 1; e.win = build3(r3, c3); qa.push_back(e); end
      if (hit(r3, c3, 3, 2)) begin e.cyc = cyc + 1; e.win = build3(r3, c3); qb.push_back(e); end
      if (c3 == 4) begin
         c3 = 0;
         if (r3 == 4) begin
            r3 = 0;
            fqa.push_back(cyc + 1);
            fqb.push_back(cyc + 1);
         end else r3++;
      end else c3++;
      @(negedge clock);
      dv8 = 1'b0;
   endtask

   task automatic send5(input int p);
      exp_t e;
      din12 = 12'(p);
      dv12  = 1'b1;
      f5[r5*8 + c5] = p;
      if (hit(r5, c5, 5, 1)) begin e.cyc = cyc + 1; e.win = build5(r5, c5); qc.push_back(e); end
      if (hit(r5, c5, 5, 3)) begin e.cyc = cyc + 1; e.win = build5(r5, c5); qd.push_back(e); end
      if (c5 == 7) begin
         c5 = 0;
         if (r5 == 5) begin
            r5 = 0;
            fqc.push_back(cyc + 1);
            fqd.push_back(cyc + 1);
         end else r5++;
      end else c5++;
      @(negedge clock);
      dv12 = 1'b0;
   endtask

   // Every idle cycle observed here follows a stall edge, so no pulse may appear.
   task automatic idle(input int n);
      dv8  = 1'b0;
      dv12 = 1'b0;
      repeat (n) begin
         @(negedge clock);
         check("stall_pulses", {wv_a, wv_b, fd_a, fd_b, wv_c, wv_d, fd_c, fd_d}, 0);
      end
   endtask

   task automatic clear_seen();
      seen_a.delete(); seen_b.delete(); seen_c.delete(); seen_d.delete();
      fd_cnt_a = 0; fd_cnt_b = 0; fd_cnt_c = 0; fd_cnt_d = 0;
      last_win_cyc_a = -1; fd_cyc_a = -2;
   endtask

   task automatic common_checks(input string tag);
      wide_t last_w;
      last_w = pack3(13, 14, 15, 18, 19, 20, 23, 24, 25);
      check({tag, "_s1_count"}, seen_a.size(), 9);
      check({tag, "_s1_first"}, (seen_a.size() > 0) ? seen_a[0] : '0,
            pack3(1, 2, 3, 6, 7, 8, 11, 12, 13));
      check({tag, "_s1_last"}, (seen_a.size() > 8) ? seen_a[8] : '0, last_w);
      check({tag, "_frame_done_count"}, fd_cnt_a, 1);
      check({tag, "_frame_done_with_last"}, fd_cyc_a, last_win_cyc_a);
      check({tag, "_s2_count"}, seen_b.size(), 4);
      check({tag, "_s2_second"}, (seen_b.size() > 1) ? seen_b[1] : '0,
            pack3(3, 4, 5, 8, 9, 10, 13, 14, 15));
      check({tag, "_s2_last"}, (seen_b.size() > 3) ? seen_b[3] : '0, last_w);
      check({tag, "_pending"}, qa.size() + qb.size() + fqa.size() + fqb.size(), 0);
   endtask

   always @(negedge clock) begin
      if (wv_a) begin
         seen_a.push_back(wide_t'(wo_a));
         last_win_cyc_a = cyc;
         check("a_window_expected", qa.size() != 0, 1);
         if (qa.size() != 0) begin
            e_a = qa.pop_front();
            check("a_window", wide_t'(wo_a), e_a.win);
            check("a_latency", cyc, e_a.cyc);
         end
      end
      if (fd_a) begin
         fd_cnt_a++;
         fd_cyc_a = cyc;
         check("a_frame_done_expected", fqa.size() != 0, 1);
         if (fqa.size() != 0) check("a_frame_done_cycle", cyc, fqa.pop_front());
      end
   end

   always @(negedge clock) begin
      if (wv_b) begin
         seen_b.push_back(wide_t'(wo_b));
         check("b_window_expected", qb.size() != 0, 1);
         if (qb.size() != 0) begin
            e_b = qb.pop_front();
            check("b_window", wide_t'(wo_b), e_b.win);
            check("b_latency", cyc, e_b.cyc);
         end
      end
      if (fd_b) begin
         fd_cnt_b++;
         check("b_frame_done_expected", fqb.size() != 0, 1);
         if (fqb.size() != 0) check("b_frame_done_cycle", cyc, fqb.pop_front());
      end
   end

   always @(negedge clock) begin
      if (wv_c) begin
         seen_c.push_back(wo_c);
         check("c_window_expected", qc.size() != 0, 1);
         if (qc.size() != 0) begin
            e_c = qc.pop_front();
            check("c_window", wo_c, e_c.win);
            check("c_latency", cyc, e_c.cyc);
         end
      end
      if (fd_c) begin
         fd_cnt_c++;
         check("c_frame_done_expected", fqc.size() != 0, 1);
         if (fqc.size() != 0) check("c_frame_done_cycle", cyc, fqc.pop_front());
      end
   end

   always @(negedge clock) begin
      if (wv_d) begin
         seen_d.push_back(wo_d);
         check("d_window_expected", qd.size() != 0, 1);
         if (qd.size() != 0) begin
            e_d = qd.pop_front();
            check("d_window", wo_d, e_d.win);
            check("d_latency", cyc, e_d.cyc);
         end
      end
      if (fd_d) begin
         fd_cnt_d++;
         check("d_frame_done_expected", fqd.size() != 0, 1);
         if (fqd.size() != 0) check("d_frame_done_cycle", cyc, fqd.pop_front());
      end
   end

   initial begin
      reset_n = 1'b0;
      dv8     = 1'b0;
      din8    = '0;
      dv12    = 1'b0;
      din12   = '0;
      clear_seen();
      repeat (2) @(negedge clock);
      check("reset_window_a", wide_t'(wo_a), 0);
      check("reset_flags", {wv_a, fd_a, wv_b, fd_b, wv_c, fd_c, wv_d, fd_d}, 0);
      check("reset_window_c", wo_c, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Contiguous frame, stride 1 and 2 in parallel.
      clear_seen();
      for (int p = 1; p <= 25; p++) send3(p);
      idle(3);
      common_checks("contig");

      // Long stall after pixel 12 plus random single-cycle gaps.
      clear_seen();
      for (int p = 1; p <= 25; p++) begin
         send3(p);
         if (p == 12) idle(3);
         else if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(3);
      common_checks("stall");

      // Asynchronous mid-frame reset, then a fresh frame.
      for (int p = 1; p <= 17; p++) send3(p);
      check("pre_reset_window_nonzero", wide_t'(wo_a) != 0, 1);
      #3 reset_n = 1'b0;
      #1;
      check("async_reset_window_a", wide_t'(wo_a), 0);
      check("async_reset_window_b", wide_t'(wo_b), 0);
      check("async_reset_flags", {wv_a, fd_a, wv_b, fd_b}, 0);
      qa.delete(); qb.delete(); fqa.delete(); fqb.delete();
      r3 = 0; c3 = 0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      clear_seen();
      for (int p = 1; p <= 25; p++) send3(p);
      idle(3);
      common_checks("after_reset");

      // Back-to-back frames with no gap.
      clear_seen();
      for (int p = 1; p <= 25; p++) send3(p);
      for (int p = 101; p <= 125; p++) send3(p);
      idle(3);
      check("b2b_s1_count", seen_a.size(), 18);
      check("b2b_s2_count", seen_b.size(), 8);
      check("b2b_frame_done_count", fd_cnt_a, 2);
      check("b2b_second_first", (seen_a.size() > 9) ? seen_a[9] : '0,
            pack3(101, 102, 103, 106, 107, 108, 111, 112, 113));
      check("b2b_pending", qa.size() + qb.size() + fqa.size() + fqb.size(), 0);

      // K=5, 8x6 image, stride 1 and 3.
      clear_seen();
      for (int p = 1; p <= 48; p++) send5(p);
      idle(3);
      check("k5_s1_count", seen_c.size(), 8);
      check("k5_s3_count", seen_d.size(), 2);
      check("k5_frame_done_count", fd_cnt_c + fd_cnt_d, 2);
      check("k5_pending", qc.size() + qd.size() + fqc.size() + fqd.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
